// File: rtl/multi_proc_sched_pkg.sv
// Shared types for the multi_proc_sched command front-end.
// Optional feature macro: MULTI_PROC_MEM_TIMEOUT_EN (memory-op watchdog).
package multi_proc_sched_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    MUL   = 3'd5,
    LOAD  = 3'd6,
    STORE = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  // Default-width command record; the top builds a width-matched copy from its parameters.
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 12;

  typedef struct packed {
    opcode_t             op;
    logic [DW_DEF-1:0]   a;
    logic [DW_DEF-1:0]   b;
    logic [AW_DEF-1:0]   addr;
    logic [DW_DEF-1:0]   wdata;
  } cmd_t;

  // LOAD and STORE go to the cache port; everything else goes to the ALU.
  function automatic logic is_mem_op(input opcode_t op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/multi_proc_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of 2), pointers wrap naturally modulo DEPTH.
// A push while full is refused even when a pop happens in the same cycle.
module multi_proc_cmd_fifo
  import multi_proc_sched_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = cmd_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  entry_t                   wdata_i,
  input  logic                     pop_i,
  output entry_t                   rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Pointer and occupancy registers; reset empties the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/multi_proc_sched.sv
// multi_proc_sched: buffered in-order command dispatcher to an internal ALU or the cache port.
// Handshakes: a channel transfers on the rising edge where valid && ready are both 1; the
// producer holds valid and payload stable until then (cmd_*, rsp_*). The cache port holds
// mem_req/we/addr/wdata stable until an edge samples mem_gnt && mem_hit.
// Optional feature macro: MULTI_PROC_MEM_TIMEOUT_EN adds a TIMEOUT-cycle watchdog on memory ops.
module multi_proc_sched
  import multi_proc_sched_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 12,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd_op,
  input  logic [DW-1:0]           cmd_a,
  input  logic [DW-1:0]           cmd_b,
  input  logic [AW-1:0]           cmd_addr,
  input  logic [DW-1:0]           cmd_wdata,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_hit,
  input  logic [DW-1:0]           mem_rdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*DW-1:0]         rsp_data,
  output logic [2:0]              rsp_op,
  output logic                    rsp_err,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output sched_state_t            dbg_state
);

  typedef struct packed {
    opcode_t         op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
  } sched_cmd_t;

  sched_state_t    state_q, state_d;
  sched_cmd_t      op_q, op_d;
  logic            mul_cnt_q, mul_cnt_d;
  logic [2*DW-1:0] rsp_data_q, rsp_data_d;
  logic [2*DW-1:0] alu_result;
  logic [2*DW-1:0] a_ext, b_ext;
  logic            load_next;
  logic            in_mem;

  sched_cmd_t      fifo_wdata, fifo_rdata;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;

`ifdef MULTI_PROC_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_err_q, rsp_err_d;
`endif

  // Pack the incoming command fields into a queue entry.
  always_comb begin
    fifo_wdata       = '0;
    fifo_wdata.op    = opcode_t'(cmd_op);
    fifo_wdata.a     = cmd_a;
    fifo_wdata.b     = cmd_b;
    fifo_wdata.addr  = cmd_addr;
    fifo_wdata.wdata = cmd_wdata;
  end

  assign fifo_push = cmd_valid;
  assign cmd_ready = !fifo_full;

  multi_proc_cmd_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (sched_cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ALU on the held operation; operands zero-extended so SUB yields a two's-complement difference.
  always_comb begin
    a_ext      = {{DW{1'b0}}, op_q.a};
    b_ext      = {{DW{1'b0}}, op_q.b};
    alu_result = '0;
    case (op_q.op)
      ADD:     alu_result = a_ext + b_ext;
      SUB:     alu_result = a_ext - b_ext;
      AND:     alu_result = a_ext & b_ext;
      OR:      alu_result = a_ext | b_ext;
      XOR:     alu_result = a_ext ^ b_ext;
      MUL:     alu_result = a_ext * b_ext;
      default: alu_result = '0;
    endcase
  end

  // Next-state logic: fetch, execute/memory wait, response hold, with direct refetch on handshake.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mul_cnt_d  = mul_cnt_q;
    rsp_data_d = rsp_data_q;
    load_next  = 1'b0;
    fifo_pop   = 1'b0;
`ifdef MULTI_PROC_MEM_TIMEOUT_EN
    tmo_d      = tmo_q;
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) load_next = 1'b1;
      end
      EXEC: begin
        // MUL spends one extra cycle here before its result is taken.
        if ((op_q.op == MUL) && !mul_cnt_q) begin
          mul_cnt_d = 1'b1;
        end else begin
          rsp_data_d = alu_result;
`ifdef MULTI_PROC_MEM_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = RESP;
        end
      end
      MEM: begin
        if (mem_gnt && mem_hit) begin
          rsp_data_d = (op_q.op == LOAD) ? {{DW{1'b0}}, mem_rdata} : {{DW{1'b0}}, op_q.wdata};
`ifdef MULTI_PROC_MEM_TIMEOUT_EN
          rsp_err_d  = 1'b0;
`endif
          state_d    = RESP;
        end
`ifdef MULTI_PROC_MEM_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          if (!fifo_empty) load_next = 1'b1;
          else             state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_next) begin
      fifo_pop  = 1'b1;
      op_d      = fifo_rdata;
      mul_cnt_d = 1'b0;
`ifdef MULTI_PROC_MEM_TIMEOUT_EN
      tmo_d     = '0;
`endif
      state_d   = is_mem_op(fifo_rdata.op) ? MEM : EXEC;
    end
  end

  // FSM and operation registers; async reset discards the in-flight op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      mul_cnt_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      mul_cnt_q  <= mul_cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef MULTI_PROC_MEM_TIMEOUT_EN
  // Watchdog counter and error flag for memory ops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign rsp_err = (state_q == RESP) && rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign in_mem    = (state_q == MEM);
  assign mem_req   = in_mem;
  assign mem_we    = in_mem && (op_q.op == STORE);
  assign mem_addr  = in_mem ? op_q.addr  : '0;
  assign mem_wdata = in_mem ? op_q.wdata : '0;

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_op    = rsp_valid ? op_q.op : 3'b000;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_multi_proc_sched.sv
// Directed bench for multi_proc_sched (DW=8, AW=12, DEPTH=4, TIMEOUT=16).
module tb_multi_proc_sched;
  import multi_proc_sched_pkg::*;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [11:0]   cmd_addr;
  logic [7:0]    cmd_wdata;
  logic          mem_req;
  logic          mem_we;
  logic [11:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_gnt;
  logic          mem_hit;
  logic [7:0]    mem_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_data;
  logic [2:0]    rsp_op;
  logic          rsp_err;
  logic [2:0]    fifo_count;
  sched_state_t  dbg_state;

  int checks;
  int failures;

  logic [15:0] exp_q[$];
  logic [2:0]  exp_op_q[$];

  multi_proc_sched #(.DW(8), .AW(12), .DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_hit    (mem_hit),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .fifo_count (fifo_count),
    .dbg_state  (dbg_state)
  );

  // Clock: 10 ns period; inputs driven and outputs sampled on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command when the FIFO can take it; returns one falling edge after the push edge.
  task automatic send_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [11:0] addr, input logic [7:0] wd);
    int waitc;
    waitc = 0;
    while (cmd_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_ready got=%b exp=1", cmd_ready);
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_addr = addr; cmd_wdata = wd;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_a = '0; cmd_b = '0; cmd_addr = '0; cmd_wdata = '0;
    mem_gnt = 1'b0; mem_hit = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
      failures++; $display("FAIL reset_mem got=%b/%b/%h/%h exp=0", mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if ({rsp_valid, rsp_data, rsp_op, rsp_err} !== '0) begin
      failures++; $display("FAIL reset_rsp got=%b/%h/%h/%b exp=0", rsp_valid, rsp_data, rsp_op, rsp_err);
    end
    checks++;
    if (fifo_count !== 3'd0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL reset_count_state got=%0d/%0d exp=0/0", fifo_count, dbg_state);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One ALU op into an idle block; rsp_valid must first appear 'lat' edges after the accept edge.
  task automatic run_alu_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input int lat, input string name);
    int early;
    rsp_ready = 1'b1;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_addr = '0; cmd_wdata = '0;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin failures++; $display("FAIL %s_ready got=%b exp=1", name, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    early = 0;
    for (int k = 1; k <= lat; k++) begin
      if (rsp_valid !== 1'b0) early++;
      if (k < lat) @(negedge clk);
    end
    checks++;
    if (early != 0) begin failures++; $display("FAIL %s_early got=%0d exp=0", name, early); end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL %s_latency got=%b exp=1", name, rsp_valid); end
    checks++;
    if (rsp_data !== exp) begin failures++; $display("FAIL %s_data got=%h exp=%h", name, rsp_data, exp); end
    checks++;
    if (rsp_op !== op || rsp_err !== 1'b0) begin
      failures++; $display("FAIL %s_op got=%0d/%b exp=%0d/0", name, rsp_op, rsp_err, op);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin failures++; $display("FAIL %s_release got=%b exp=0", name, rsp_valid); end
  endtask

  task automatic test_alu();
    run_alu_op(ADD, 8'hFF, 8'h01, 16'h0100, 2, "add_carry");
    run_alu_op(SUB, 8'h01, 8'h02, 16'hFFFF, 2, "sub_neg");
    run_alu_op(MUL, 8'hFF, 8'hFF, 16'hFE01, 3, "mul_max");
    run_alu_op(AND, 8'hF0, 8'h3C, 16'h0030, 2, "and");
    run_alu_op(OR,  8'hF0, 8'h0F, 16'h00FF, 2, "or");
    run_alu_op(XOR, 8'hAA, 8'hFF, 16'h0055, 2, "xor");
    run_alu_op(MUL, 8'h0C, 8'h0A, 16'h0078, 3, "mul_small");
    run_alu_op(ADD, 8'h12, 8'h34, 16'h0046, 2, "add_small");
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [5];
    logic [7:0] as  [5];
    logic [7:0] bs  [5];
    logic [15:0] got_exp;
    int notready;
    ops[0] = ADD; as[0] = 8'h01; bs[0] = 8'h02; exp_q.push_back(16'h0003); exp_op_q.push_back(ADD);
    ops[1] = SUB; as[1] = 8'h05; bs[1] = 8'h03; exp_q.push_back(16'h0002); exp_op_q.push_back(SUB);
    ops[2] = MUL; as[2] = 8'h03; bs[2] = 8'h04; exp_q.push_back(16'h000C); exp_op_q.push_back(MUL);
    ops[3] = XOR; as[3] = 8'h0F; bs[3] = 8'hFF; exp_q.push_back(16'h00F0); exp_op_q.push_back(XOR);
    ops[4] = OR;  as[4] = 8'h10; bs[4] = 8'h01; exp_q.push_back(16'h0011); exp_op_q.push_back(OR);
    rsp_ready = 1'b0;
    notready = 0;
    // Five consecutive pushes: one is popped into execution, four fill the FIFO.
    for (int i = 0; i < 5; i++) begin
      cmd_op = ops[i]; cmd_a = as[i]; cmd_b = bs[i]; cmd_valid = 1'b1;
      if (cmd_ready !== 1'b1) notready++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    checks++;
    if (notready != 0) begin failures++; $display("FAIL b2b_accept got=%0d refusals exp=0", notready); end
    checks++;
    if (cmd_ready !== 1'b0 || fifo_count !== 3'd4) begin
      failures++; $display("FAIL b2b_full got=ready%b/count%0d exp=ready0/count4", cmd_ready, fifo_count);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_hold got=%b exp=1", rsp_valid); end
    // Release the consumer while pushing into the full FIFO: the pop frees a slot but the push is refused.
    rsp_ready = 1'b1;
    cmd_op = AND; cmd_a = 8'hFF; cmd_b = 8'h0F; cmd_valid = 1'b1;
    got_exp = exp_q.pop_front();
    checks++;
    if (rsp_data !== got_exp || rsp_op !== exp_op_q.pop_front()) begin
      failures++; $display("FAIL b2b_rsp0 got=%h exp=%h", rsp_data, got_exp);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd3) begin failures++; $display("FAIL full_push_pop got=%0d exp=3", fifo_count); end
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      if (rsp_valid === 1'b1) begin
        got_exp = exp_q.pop_front();
        checks++;
        if (rsp_data !== got_exp || rsp_op !== exp_op_q.pop_front()) begin
          failures++; $display("FAIL b2b_order got=%h/%0d exp=%h", rsp_data, rsp_op, got_exp);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL b2b_timeout got=%0d left exp=0", exp_q.size());
      exp_q.delete(); exp_op_q.delete();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain got=count%0d/valid%b exp=0/0", fifo_count, rsp_valid);
    end
  endtask

  task automatic test_load();
    int unstable;
    rsp_ready = 1'b1; mem_gnt = 1'b0; mem_hit = 1'b0;
    send_cmd(LOAD, 8'h00, 8'h00, 12'h123, 8'h00);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h123) begin
      failures++; $display("FAIL load_req got=%b/%b/%h exp=1/0/123", mem_req, mem_we, mem_addr);
    end
    unstable = 0;
    for (int i = 0; i < 3; i++) begin
      mem_gnt = 1'b1; mem_hit = 1'b0; mem_rdata = 8'hEE;
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h123 || rsp_valid !== 1'b0) unstable++;
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL load_miss got=%0d unstable cycles exp=0", unstable); end
    mem_hit = 1'b1; mem_rdata = 8'h5A;
    @(negedge clk);
    mem_gnt = 1'b0; mem_hit = 1'b0; mem_rdata = 8'h00;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h005A || rsp_op !== LOAD || rsp_err !== 1'b0) begin
      failures++; $display("FAIL load_rsp got=%b/%h/%0d exp=1/005a/6", rsp_valid, rsp_data, rsp_op);
    end
    checks++;
    if (mem_req !== 1'b0) begin failures++; $display("FAIL load_req_drop got=%b exp=0", mem_req); end
    @(negedge clk);
  endtask

  task automatic test_store();
    int unstable;
    rsp_ready = 1'b1; mem_gnt = 1'b0; mem_hit = 1'b0;
    send_cmd(STORE, 8'h00, 8'h00, 12'h7FF, 8'h3C);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h7FF || mem_wdata !== 8'h3C) begin
      failures++; $display("FAIL store_req got=%b/%b/%h/%h exp=1/1/7ff/3c", mem_req, mem_we, mem_addr, mem_wdata);
    end
    unstable = 0;
    // Hit without grant does not complete the access.
    for (int i = 0; i < 2; i++) begin
      mem_gnt = 1'b0; mem_hit = 1'b1;
      @(negedge clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 8'h3C || rsp_valid !== 1'b0) unstable++;
    end
    checks++;
    if (unstable != 0) begin failures++; $display("FAIL store_wait got=%0d unstable cycles exp=0", unstable); end
    mem_gnt = 1'b1; mem_hit = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_hit = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h003C || rsp_op !== STORE || mem_req !== 1'b0) begin
      failures++; $display("FAIL store_rsp got=%b/%h/%0d/req%b exp=1/003c/7/req0", rsp_valid, rsp_data, rsp_op, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    int seen;
    rsp_ready = 1'b0; mem_gnt = 1'b0; mem_hit = 1'b0;
    send_cmd(LOAD, 8'h00, 8'h00, 12'h456, 8'h00);
    send_cmd(ADD, 8'h01, 8'h01, 12'h000, 8'h00);
    send_cmd(ADD, 8'h02, 8'h02, 12'h000, 8'h00);
    checks++;
    if (mem_req !== 1'b1 || fifo_count !== 3'd2) begin
      failures++; $display("FAIL midrst_setup got=req%b/count%0d exp=req1/count2", mem_req, fifo_count);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || fifo_count !== 3'd0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL midrst_async got=req%b/count%0d/st%0d exp=0/0/0", mem_req, fifo_count, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_req !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || fifo_count !== 3'd0 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL midrst_after got=%0d activity/count%0d exp=0/0", seen, fifo_count);
    end
  endtask

`ifdef MULTI_PROC_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int req_cycles;
    rsp_ready = 1'b0; mem_gnt = 1'b1; mem_hit = 1'b0;
    send_cmd(LOAD, 8'h00, 8'h00, 12'h0AA, 8'h00);
    @(negedge clk);
    req_cycles = 0;
    while (mem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      @(negedge clk);
    end
    checks++;
    if (req_cycles != 16) begin failures++; $display("FAIL timeout_len got=%0d exp=16", req_cycles); end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 16'h0000) begin
      failures++; $display("FAIL timeout_rsp got=%b/%b/%h exp=1/1/0000", rsp_valid, rsp_err, rsp_data);
    end
    mem_gnt = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_store();
`ifdef MULTI_PROC_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
